// File: rtl/systolic_pkg.sv
// Shared framing arithmetic and feeder state encoding, used by the feeder and the product collector.
// Frame length L = 2N + G; the bit counter spans 0..L-1.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAD   = 2'd2
    } feeder_state_t;

    function automatic int FRAME_LEN(input int n, input int g);
        return 2 * n + g;
    endfunction

    function automatic int CNT_W(input int n, input int g);
        return (FRAME_LEN(n, g) > 1) ? $clog2(FRAME_LEN(n, g)) : 1;
    endfunction

endpackage

// File: rtl/systolic_piso_reg.sv
// N-bit load/shift register, LSB out first, with a fill bit shifted into the MSB.
// Latency: loaded word bit 0 visible the cycle after load; no backpressure (controlled by the feeder FSM).
// Priority: load > clear > shift.
module systolic_piso_reg #(
    parameter int p_WIDTH = 4
) (
    input  logic               i_CLK,
    input  logic               i_RST_N,
    input  logic               i_LOAD,
    input  logic               i_CLEAR,
    input  logic               i_SHIFT,
    input  logic               i_FILL,
    input  logic [p_WIDTH-1:0] i_DATA,
    output logic               o_BIT
);

    logic [p_WIDTH-1:0] sr_q;
    logic [p_WIDTH-1:0] sr_d;
    logic [p_WIDTH-1:0] fill_vec;

    assign fill_vec = {{(p_WIDTH-1){1'b0}}, i_FILL} << (p_WIDTH - 1);

    always_comb begin
        sr_d = sr_q;
        if (i_LOAD) begin
            sr_d = i_DATA;
        end else if (i_CLEAR) begin
            sr_d = '0;
        end else if (i_SHIFT) begin
            sr_d = (sr_q >> 1) | fill_vec;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_BIT = sr_q[0];

endmodule

// File: rtl/systolic_mult_feeder.sv
// Operand sequencer for the bit-serial systolic multiplier: holds the multiplier, serialises the multiplicand LSB-first,
// pads to L = 2N+G bits. First bit 1 clock after accept; o_READY only in IDLE or on the last frame bit (zero-gap chaining).
// Build option SYSTOLIC_FEEDER_SIGNED_EN: pad bits repeat the multiplicand sign instead of 0.
module systolic_mult_feeder
    import systolic_pkg::*;
#(
    parameter int p_WORD_WIDTH   = 4,
    parameter int p_GUARD_CYCLES = 2
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    input  logic                    i_VALID,
    output logic                    o_READY,
    input  logic [p_WORD_WIDTH-1:0] i_MULTIPLIER,
    input  logic [p_WORD_WIDTH-1:0] i_MULTIPLICAND,
    output logic [p_WORD_WIDTH-1:0] o_MULTIPLIER,
    output logic                    o_MULTIPLICAND_BIT,
    output logic                    o_BIT_VALID,
    output logic                    o_FRAME_START,
    output logic                    o_FRAME_LAST,
    output logic                    o_BUSY
);

    localparam int L  = FRAME_LEN(p_WORD_WIDTH, p_GUARD_CYCLES);
    localparam int CW = CNT_W(p_WORD_WIDTH, p_GUARD_CYCLES);
    localparam logic [CW-1:0] K_LAST   = CW'(L - 1);
    localparam logic [CW-1:0] K_SHLAST = CW'(p_WORD_WIDTH - 1);

    feeder_state_t          state_q;
    logic [CW-1:0]          k_q;
    logic [CW-1:0]          k_inc;
    logic [p_WORD_WIDTH-1:0] mult_q;
    logic                   bit_valid_q;
    logic                   busy_q;
    logic                   frame_start_q;
    logic                   frame_last_q;
    logic                   accept;
    logic                   at_last;
    logic                   sr_load;
    logic                   sr_clear;
    logic                   sr_shift;
    logic                   pad_fill;

    assign at_last = (state_q == ST_PAD) && (k_q == K_LAST);
    assign o_READY = (state_q == ST_IDLE) || at_last;
    assign accept  = i_VALID && o_READY;
    assign k_inc   = k_q + CW'(1);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            mult_q        <= '0;
            bit_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            if (accept) begin
                mult_q <= i_MULTIPLIER;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q       <= ST_SHIFT;
                        k_q           <= '0;
                        bit_valid_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        frame_start_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    k_q          <= k_inc;
                    // Only reachable as "last" when the frame is a single shift bit plus one pad bit.
                    frame_last_q <= (k_inc == K_LAST);
                    if (k_q == K_SHLAST) begin
                        state_q <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (k_q == K_LAST) begin
                        k_q <= '0;
                        if (accept) begin
                            state_q       <= ST_SHIFT;
                            frame_start_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            bit_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        k_q          <= k_inc;
                        frame_last_q <= (k_inc == K_LAST);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    k_q         <= '0;
                    bit_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Clearing at the end of an unchained frame keeps the serial output at 0 while idle.
    assign sr_load  = accept;
    assign sr_clear = at_last && !accept;
    assign sr_shift = (state_q != ST_IDLE);

`ifdef SYSTOLIC_FEEDER_SIGNED_EN
    logic sign_q;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= i_MULTIPLICAND[p_WORD_WIDTH-1];
        end
    end

    assign pad_fill = sign_q;
`else
    assign pad_fill = 1'b0;
`endif

    systolic_piso_reg #(
        .p_WIDTH (p_WORD_WIDTH)
    ) u_piso (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_LOAD  (sr_load),
        .i_CLEAR (sr_clear),
        .i_SHIFT (sr_shift),
        .i_FILL  (pad_fill),
        .i_DATA  (i_MULTIPLICAND),
        .o_BIT   (o_MULTIPLICAND_BIT)
    );

    assign o_MULTIPLIER  = mult_q;
    assign o_BIT_VALID   = bit_valid_q;
    assign o_BUSY        = busy_q;
    assign o_FRAME_START = frame_start_q;
    assign o_FRAME_LAST  = frame_last_q;

endmodule

// File: tb/tb_systolic_mult_feeder.sv
// Self-checking bench for systolic_mult_feeder (N=4, G=2): frame-queue reference model plus product collector.
module tb_systolic_mult_feeder;

    localparam int N = 4;
    localparam int G = 2;
    localparam int L = 2 * N + G;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic         ready;
    logic [N-1:0] mp_in;
    logic [N-1:0] mc_in;
    logic [N-1:0] mp_out;
    logic         mc_bit;
    logic         bit_valid;
    logic         frame_start;
    logic         frame_last;
    logic         busy;

    systolic_mult_feeder #(
        .p_WORD_WIDTH   (N),
        .p_GUARD_CYCLES (G)
    ) dut (
        .i_CLK              (clk),
        .i_RST_N            (rst_n),
        .i_VALID            (valid),
        .o_READY            (ready),
        .i_MULTIPLIER       (mp_in),
        .i_MULTIPLICAND     (mc_in),
        .o_MULTIPLIER       (mp_out),
        .o_MULTIPLICAND_BIT (mc_bit),
        .o_BIT_VALID        (bit_valid),
        .o_FRAME_START      (frame_start),
        .o_FRAME_LAST       (frame_last),
        .o_BUSY             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic st;
        logic ls;
    } item_t;

    typedef struct {
        logic [N-1:0]   mp;
        logic [N-1:0]   mc;
        logic [2*N-1:0] prod;
    } vec_t;

    item_t          exp_q[$];
    logic [N-1:0]   m_mult;
    logic [2*N-1:0] got_prod[$];
    logic [2*N-1:0] want_prod[$];
    logic [2*N-1:0] col_bits;
    int             col_idx;
    int             n_checks;
    int             n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic pad_of(input logic [N-1:0] mc);
`ifdef SYSTOLIC_FEEDER_SIGNED_EN
        return mc[N-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] mp, input logic [N-1:0] mc);
        logic [2*N-1:0] a;
`ifdef SYSTOLIC_FEEDER_SIGNED_EN
        a = {{N{mc[N-1]}}, mc};
`else
        a = {{N{1'b0}}, mc};
`endif
        return a * {{N{1'b0}}, mp};
    endfunction

    task automatic push_frame(input logic [N-1:0] mc);
        item_t it;
        for (int t = 0; t < L; t++) begin
            it.b  = (t < N) ? mc[t] : pad_of(mc);
            it.st = (t == 0);
            it.ls = (t == L - 1);
            exp_q.push_back(it);
        end
    endtask

    task automatic check_outputs();
        item_t e;
        logic  have;
        have = (exp_q.size() > 0);
        e = '{b: 1'b0, st: 1'b0, ls: 1'b0};
        if (have) e = exp_q[0];
        chk("ready", ready, (exp_q.size() <= 1));
        chk("bit_valid", bit_valid, have);
        chk("busy", busy, have);
        chk("mcand_bit", mc_bit, e.b);
        chk("frame_start", frame_start, e.st);
        chk("frame_last", frame_last, e.ls);
        chk("multiplier", mp_out, m_mult);
        if (frame_start) begin
            col_bits = '0;
            col_idx  = 0;
        end
        if (bit_valid) begin
            if (col_idx < 2 * N) col_bits[col_idx] = mc_bit;
            col_idx++;
        end
        if (frame_last) got_prod.push_back(col_bits * {{N{1'b0}}, mp_out});
    endtask

    task automatic tick(output logic acc);
        acc = valid && (exp_q.size() <= 1);
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            push_frame(mc_in);
            m_mult = mp_in;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [N-1:0] mp, input logic [N-1:0] mc, input string nm);
        logic acc;
        valid = 1'b1;
        mp_in = mp;
        mc_in = mc;
        acc   = 1'b0;
        for (int c = 0; c < 3 * L && !acc; c++) tick(acc);
        if (!acc) chk({nm, "_accept_timeout"}, 0, 1);
    endtask

    task automatic drain();
        logic acc;
        valid = 1'b0;
        repeat (L + 2) tick(acc);
    endtask

    task automatic cmp_products(input string nm);
        logic [2*N-1:0] g;
        logic [2*N-1:0] w;
        while (want_prod.size() > 0) begin
            w = want_prod.pop_front();
            if (got_prod.size() == 0) begin
                chk({nm, "_missing_product"}, 0, {24'd0, w});
            end else begin
                g = got_prod.pop_front();
                chk({nm, "_product"}, {24'd0, g}, {24'd0, w});
            end
        end
        chk({nm, "_extra_products"}, got_prod.size(), 0);
        got_prod.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_bit_valid"}, bit_valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_bit"}, mc_bit, 0);
        chk({nm, "_start"}, frame_start, 0);
        chk({nm, "_last"}, frame_last, 0);
        chk({nm, "_multiplier"}, mp_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[4];
    logic acc;
    int   waited;

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_mult   = '0;
        col_bits = '0;
        col_idx  = 0;
`ifdef SYSTOLIC_FEEDER_SIGNED_EN
        tbl[0] = '{mp: 4'hB, mc: 4'h6, prod: 8'h42};
        tbl[1] = '{mp: 4'h3, mc: 4'h5, prod: 8'h0F};
        tbl[2] = '{mp: 4'hF, mc: 4'hF, prod: 8'hF1};
        tbl[3] = '{mp: 4'h3, mc: 4'hA, prod: 8'hEE};
`else
        tbl[0] = '{mp: 4'hB, mc: 4'h6, prod: 8'h42};
        tbl[1] = '{mp: 4'h3, mc: 4'h5, prod: 8'h0F};
        tbl[2] = '{mp: 4'hF, mc: 4'hF, prod: 8'hE1};
        tbl[3] = '{mp: 4'h3, mc: 4'hA, prod: 8'h1E};
`endif

        // Reset held for 3 cycles.
        rst_n = 1'b0;
        valid = 1'b0;
        mp_in = '0;
        mc_in = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", ready, 1);

        // Table vectors with valid held throughout: frames must chain with no gap.
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].mp, tbl[i].mc, "table");
            want_prod.push_back(tbl[i].prod);
        end
        drain();
        cmp_products("table");

        // Valid raised mid-frame at bit 3: held off until bit 9, then chained.
        send(4'h2, 4'h7, "late");
        want_prod.push_back(ref_prod(4'h2, 4'h7));
        valid = 1'b0;
        repeat (3) tick(acc);
        valid  = 1'b1;
        mp_in  = 4'h9;
        mc_in  = 4'hC;
        acc    = 1'b0;
        waited = 0;
        while (!acc && waited < 3 * L) begin
            tick(acc);
            waited++;
        end
        chk("late_accept_cycles", waited, 7);
        want_prod.push_back(ref_prod(4'h9, 4'hC));
        drain();
        cmp_products("late");

        // Reset pulse at frame bit 5: asynchronous clear, partial frame dropped.
        send(4'h5, 4'h3, "abort");
        valid = 1'b0;
        repeat (5) tick(acc);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        m_mult   = '0;
        col_bits = '0;
        col_idx  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_abort", ready, 1);
        send(4'hD, 4'h9, "post_abort");
        want_prod.push_back(ref_prod(4'hD, 4'h9));
        drain();
        cmp_products("post_abort");

        // Randomised traffic with random idle gaps.
        for (int f = 0; f < 150; f++) begin
            logic [N-1:0] rmp;
            logic [N-1:0] rmc;
            rmp   = N'($urandom);
            rmc   = N'($urandom);
            valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick(acc);
            send(rmp, rmc, "rand");
            want_prod.push_back(ref_prod(rmp, rmc));
        end
        drain();
        cmp_products("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
